// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: FSM state encoding
// and default sizing constants.
package rr_onehot_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int ARB_MAX_HOLD = 15;

endpackage

// File: rtl/rr_onehot_arbiter_onehot_dec.sv
// Combinational binary-to-one-hot decoder used to form the arbiter grant vector.
module onehot_dec #(
  parameter int IDX_W = 3,
  parameter int N     = 8
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dec
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary index.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = ARB_IDX_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  generate
    if ((1 << IDX_W) != N || N < 2 || MAX_HOLD < 2) begin : g_bad_params
      $error("rr_onehot_arbiter: N must equal 2**IDX_W (>= 2) and MAX_HOLD >= 2");
    end
  endgenerate

  arb_state_t       state_reg;
  logic [N-1:0]     gnt_reg;
  logic [IDX_W-1:0] gnt_idx_reg;
  logic             gnt_valid_reg;
  logic [IDX_W-1:0] ptr_reg;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_onehot;
  logic             owner_rel;
  logic             rel_now;

  // First requester at or after ptr; index arithmetic wraps because N = 2**IDX_W.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_reg + IDX_W'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  onehot_dec #(
    .IDX_W (IDX_W),
    .N     (N)
  ) u_dec (
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  assign owner_rel = done | ~req[gnt_idx_reg];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              timeout_reg;
  logic              force_rel;

  assign force_rel = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign rel_now   = owner_rel | force_rel;
  assign timeout   = timeout_reg;
`else
  assign rel_now   = owner_rel;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      ptr_reg       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (sel_found) begin
            state_reg     <= ST_GRANT;
            gnt_reg       <= sel_onehot;
            gnt_idx_reg   <= sel_idx;
            gnt_valid_reg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (rel_now) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            ptr_reg       <= gnt_idx_reg + 1'b1;
`ifdef ARB_TIMEOUT_EN
            // Only flag a timeout when the owner was not releasing anyway.
            timeout_reg   <= ~owner_rel;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
`endif
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: per-cycle vector table plus
// hand-written sequences for round-robin wrap and long-hold behaviour.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int failures;

  rr_onehot_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    logic       exp_valid;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  // Drive inputs on the falling edge, sample outputs just after the rising edge.
  task automatic step(input logic r, input logic [7:0] q, input logic d);
    @(negedge clk);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] ix,
                       input logic v, input logic t);
    checks++;
    if (gnt !== g || gnt_idx !== ix || gnt_valid !== v || timeout !== t) begin
      failures++;
      $display("FAIL %s: got gnt=%02h idx=%0d valid=%0b timeout=%0b, want gnt=%02h idx=%0d valid=%0b timeout=%0b",
               name, gnt, gnt_idx, gnt_valid, timeout, g, ix, v, t);
    end else begin
      $display("ok   %s: gnt=%02h idx=%0d valid=%0b timeout=%0b", name, gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask

  initial begin
    int held;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    done     = 1'b0;

    //            rst   req    done  gnt    idx  valid
    vecs[0]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0}; // reset holds with all requests
    vecs[1]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1}; // first grant from ptr 0
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0}; // done -> ptr 1
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, 8'h02, 3'd1, 1'b1}; // ptr 1 honoured
    vecs[5]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr 2
    vecs[6]  = '{1'b1, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1};
    vecs[7]  = '{1'b1, 8'h10, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr 5
    vecs[8]  = '{1'b1, 8'h09, 1'b0, 8'h01, 3'd0, 1'b1}; // search 5,6,7,0
    vecs[9]  = '{1'b1, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr 1
    vecs[10] = '{1'b1, 8'h09, 1'b0, 8'h08, 3'd3, 1'b1};
    vecs[11] = '{1'b1, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr 4
    vecs[12] = '{1'b1, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1}; // wrap search to idx 2
    vecs[13] = '{1'b1, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1}; // held
    vecs[14] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0}; // req drop releases, ptr 3
    vecs[15] = '{1'b1, 8'h0C, 1'b0, 8'h08, 3'd3, 1'b1};
    vecs[16] = '{1'b0, 8'h0C, 1'b0, 8'h00, 3'd0, 1'b0}; // reset mid-grant
    vecs[17] = '{1'b1, 8'h0C, 1'b0, 8'h04, 3'd2, 1'b1}; // ptr back to 0
    vecs[18] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // done + drop = one release, ptr 3
    vecs[19] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // done in idle ignored
    vecs[20] = '{1'b1, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
    vecs[21] = '{1'b1, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0}; // ptr wraps 7 -> 0
    vecs[22] = '{1'b1, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[23] = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1}; // new request waits
    vecs[24] = '{1'b1, 8'h03, 1'b1, 8'h00, 3'd0, 1'b0}; // mandatory idle cycle
    vecs[25] = '{1'b1, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx, vecs[i].exp_valid, 1'b0);
    end

    // Full rotation with every requester active, including wrap back to 0.
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e_idx;
      logic [7:0] e_gnt;
      e_idx = 3'(k % 8);
      e_gnt = 8'h01 << e_idx;
      step(1'b1, 8'hFF, 1'b0);
      check($sformatf("rot%0d_grant", k), e_gnt, e_idx, 1'b1, 1'b0);
      step(1'b1, 8'hFF, 1'b1);
      check($sformatf("rot%0d_idle", k), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Long hold: single requester, never signals done.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    check("hold_first", 8'h10, 3'd4, 1'b1, 1'b0);
    held = 1;
    for (int c = 0; c < 120; c++) begin
      if (gnt !== 8'h10) break;
      step(1'b1, 8'h10, 1'b0);
      if (gnt === 8'h10) held++;
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (held != 15) begin
      failures++;
      $display("FAIL hold_len: got %0d cycles, want 15", held);
    end else begin
      $display("ok   hold_len: %0d cycles", held);
    end
    check("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0);
    check("timeout_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
`else
    checks++;
    if (held < 100) begin
      failures++;
      $display("FAIL hold_len: got %0d cycles, want >= 100", held);
    end else begin
      $display("ok   hold_len: %0d cycles", held);
    end
    step(1'b1, 8'h10, 1'b1);
    check("hold_release", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
